// File: rtl/cell_map_ctrl_if.sv
// Request/acknowledge bundle between the game logic (mouse, AI) and the cell map owner.
interface cell_map_ctrl_if;
    logic       new_game;
    logic       place_req;
    logic [3:0] place_x;
    logic [3:0] place_y;
    logic       place_ack;
    logic       place_ok;
    logic       ply_req;
    logic [3:0] ply_x;
    logic [3:0] ply_y;
    logic       ply_ack;
    logic       ply_hit;
    logic       ai_req;
    logic [3:0] ai_x;
    logic [3:0] ai_y;
    logic       ai_ack;
    logic       ai_hit;
    logic       req_err;
    logic       busy;

    // Game side: issues requests, observes acknowledges.
    modport master (
        output new_game, place_req, place_x, place_y, ply_req, ply_x, ply_y,
               ai_req, ai_x, ai_y,
        input  place_ack, place_ok, ply_ack, ply_hit, ai_ack, ai_hit, req_err, busy
    );

    // Map owner side.
    modport slave (
        input  new_game, place_req, place_x, place_y, ply_req, ply_x, ply_y,
               ai_req, ai_x, ai_y,
        output place_ack, place_ok, ply_ack, ply_hit, ai_ack, ai_hit, req_err, busy
    );
endinterface

// File: rtl/cell_map_ctrl.sv
// Battleship cell-status map: VGA read port plus an arbitrated read-modify-write port
// shared by ship placement, player shots and AI shots.
module cell_map_ctrl #(
    parameter int unsigned GRID_W = 10,
    parameter int unsigned GRID_H = 10,
    parameter int unsigned CELL_W = 64,
    parameter int unsigned CELL_H = 48
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          enable,
    input  logic [9:0]    pix_row,
    input  logic [9:0]    pix_line,
    output logic [3:0]    cell_status,
    cell_map_ctrl_if.slave bus
);
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned XSH   = $clog2(CELL_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
    localparam logic [3:0] GW = 4'(GRID_W);
    localparam logic [3:0] GH = 4'(GRID_H);

    localparam logic [3:0] ST_FREE = 4'd0;
    localparam logic [3:0] ST_OCC  = 4'd1;
    localparam logic [3:0] ST_PHIT = 4'd2;
    localparam logic [3:0] ST_AHIT = 4'd3;
    localparam logic [3:0] ST_BOTH = 4'd4;

    typedef enum logic [1:0] {StClear, StIdle, StRead, StWrite} state_t;
    typedef enum logic [1:0] {RqPlace, RqPly, RqAi} req_t;

    state_t        state;
    req_t          gnt_q;
    req_t          rr_last;
    logic [IW-1:0] clr_idx;
    logic [3:0]    x_q;
    logic [3:0]    y_q;
    logic [3:0]    wr_data_q;
    logic [3:0]    map_q [CELLS];

    logic          gnt_valid;
    logic          contested;
    req_t          gnt_sel;
    logic [3:0]    gnt_x;
    logic [3:0]    gnt_y;
    logic          in_range;
    logic [IW-1:0] req_idx;
    logic [3:0]    old_status;
    logic [3:0]    new_status;

    logic [IW-1:0] px_cell;
    logic [3:0]    py_cell;
    logic          pix_in;
    logic [IW-1:0] pix_idx;

    // Arbitration: placement first, then round-robin between the two shooters.
    // rr_last only moves on a contested grant, so a lone shooter does not steal the turn.
    always_comb begin
        gnt_valid = 1'b0;
        contested = 1'b0;
        gnt_sel   = RqPlace;
        gnt_x     = bus.place_x;
        gnt_y     = bus.place_y;
        if (bus.place_req) begin
            gnt_valid = 1'b1;
        end else if (bus.ply_req && bus.ai_req) begin
            gnt_valid = 1'b1;
            contested = 1'b1;
            gnt_sel   = (rr_last == RqAi) ? RqPly : RqAi;
        end else if (bus.ply_req) begin
            gnt_valid = 1'b1;
            gnt_sel   = RqPly;
        end else if (bus.ai_req) begin
            gnt_valid = 1'b1;
            gnt_sel   = RqAi;
        end
        if (gnt_sel == RqPly) begin
            gnt_x = bus.ply_x;
            gnt_y = bus.ply_y;
        end else if (gnt_sel == RqAi) begin
            gnt_x = bus.ai_x;
            gnt_y = bus.ai_y;
        end
    end

    // Old status of the latched cell and the status the granted request turns it into.
    always_comb begin
        in_range   = (x_q < GW) && (y_q < GH);
        req_idx    = in_range ? IW'(IW'(y_q) * IW'(GRID_W) + IW'(x_q)) : '0;
        old_status = in_range ? map_q[req_idx] : ST_FREE;
        new_status = old_status;
        unique case (gnt_q)
            RqPlace: begin
                if (old_status == ST_FREE) new_status = ST_OCC;
            end
            RqPly: begin
                if (old_status == ST_FREE || old_status == ST_OCC) new_status = ST_PHIT;
                else if (old_status == ST_AHIT) new_status = ST_BOTH;
            end
            RqAi: begin
                if (old_status == ST_FREE || old_status == ST_OCC) new_status = ST_AHIT;
                else if (old_status == ST_PHIT) new_status = ST_BOTH;
            end
            default: new_status = old_status;
        endcase
    end

    // Control FSM: clear sweep, grant, read (flags + ack registered), write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= StClear;
            clr_idx       <= '0;
            gnt_q         <= RqPlace;
            rr_last       <= RqAi;
            x_q           <= '0;
            y_q           <= '0;
            wr_data_q     <= '0;
            bus.busy      <= 1'b1;
            bus.place_ack <= 1'b0;
            bus.place_ok  <= 1'b0;
            bus.ply_ack   <= 1'b0;
            bus.ply_hit   <= 1'b0;
            bus.ai_ack    <= 1'b0;
            bus.ai_hit    <= 1'b0;
            bus.req_err   <= 1'b0;
        end else begin
            bus.place_ack <= 1'b0;
            bus.place_ok  <= 1'b0;
            bus.ply_ack   <= 1'b0;
            bus.ply_hit   <= 1'b0;
            bus.ai_ack    <= 1'b0;
            bus.ai_hit    <= 1'b0;
            bus.req_err   <= 1'b0;
            unique case (state)
                StClear: begin
                    map_q[clr_idx] <= ST_FREE;
                    if (clr_idx == LAST_IDX) begin
                        clr_idx  <= '0;
                        state    <= StIdle;
                        bus.busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                StIdle: begin
                    if (bus.new_game) begin
                        clr_idx  <= '0;
                        state    <= StClear;
                        bus.busy <= 1'b1;
                    end else if (gnt_valid) begin
                        gnt_q    <= gnt_sel;
                        x_q      <= gnt_x;
                        y_q      <= gnt_y;
                        state    <= StRead;
                        bus.busy <= 1'b1;
                        if (contested) rr_last <= gnt_sel;
                    end
                end
                StRead: begin
                    // Flags are registered here so they sit alongside the ack in WRITE.
                    wr_data_q   <= new_status;
                    bus.req_err <= !in_range;
                    unique case (gnt_q)
                        RqPlace: begin
                            bus.place_ack <= 1'b1;
                            bus.place_ok  <= in_range && (old_status == ST_FREE);
                        end
                        RqPly: begin
                            bus.ply_ack <= 1'b1;
                            bus.ply_hit <= in_range && (old_status == ST_OCC);
                        end
                        RqAi: begin
                            bus.ai_ack <= 1'b1;
                            bus.ai_hit <= in_range && (old_status == ST_OCC);
                        end
                        default: ;
                    endcase
                    state <= StWrite;
                end
                StWrite: begin
                    if (in_range) map_q[req_idx] <= wr_data_q;
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
                default: state <= StClear;
            endcase
        end
    end

    // Pixel to cell: x by shift, y by compare chain on multiples of CELL_H.
    always_comb begin
        px_cell = IW'(pix_row >> XSH);
        py_cell = '0;
        for (int k = 1; k < int'(GRID_H); k++) begin
            if (int'(pix_line) >= k * int'(CELL_H)) py_cell = py_cell + 4'd1;
        end
        pix_in  = (int'(pix_row) < int'(GRID_W * CELL_W)) &&
                  (int'(pix_line) < int'(GRID_H * CELL_H));
        pix_idx = pix_in ? IW'(IW'(py_cell) * IW'(GRID_W) + px_cell) : '0;
    end

    // VGA read port: registered, never stalled by the FSM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cell_status <= '0;
        end else if (enable && pix_in) begin
            cell_status <= map_q[pix_idx];
        end else begin
            cell_status <= '0;
        end
    end
endmodule
